// File: rtl/spi_regfile.sv
// SPI-mode-0 slave register file: deferred (pending) or immediate writes, readback on MISO.
// Pending values are promoted to live registers by a single load_new strobe.
module spi_regfile #(
    parameter int                          NUM_REGS    = 16,
    parameter int                          ADDR_W      = 4,
    parameter int                          DATA_W      = 24,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_sclk,
    input  logic                         i_ss_n,
    input  logic                         i_mosi,
    output logic                         o_miso,
    output logic                         o_miso_oe,
    input  logic                         load_new,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          pending
);
    localparam int HDR_LEN = 2 + ADDR_W;
    localparam int CNT_MAX = (HDR_LEN > DATA_W) ? HDR_LEN : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, HDR, DAT} state_t;

    logic [2:0]                        sclk_q;
    logic [1:0]                        ss_q, mosi_q;
    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [HDR_LEN-1:0]                hdr_q, hdr_d, hdr_sh;
    logic [DATA_W-1:0]                 dat_q, dat_d, miso_q, miso_d, rdata;
    logic                              armed_q, armed_d, commit_q, commit_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   live_q, slot_q;
    logic [NUM_REGS-1:0]               pend_q, wr_hit;

    logic sclk_rise, sclk_fall, ss_act, mosi_s;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_act    = ~ss_q[1];
    assign mosi_s    = mosi_q[1];
    assign hdr_sh    = {hdr_q[HDR_LEN-2:0], mosi_s};

    // Read data is selected from the header as it completes on the last header rise.
    always_comb begin
        rdata = '0;
        for (int n = 0; n < NUM_REGS; n++)
            if (hdr_sh[ADDR_W-1:0] == ADDR_W'(n)) rdata = live_q[n];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        dat_d    = dat_q;
        miso_d   = miso_q;
        commit_d = 1'b0;
        armed_d  = armed_q | ~ss_act;
        if (!ss_act) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (armed_q) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
                HDR: if (sclk_rise) begin
                    hdr_d = hdr_sh;
                    if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
                        state_d = DAT;
                        cnt_d   = '0;
                        miso_d  = hdr_sh[HDR_LEN-1] ? rdata : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DAT: if (sclk_rise) begin
                    dat_d = (dat_q << 1) | DATA_W'(mosi_s);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = HDR;
                        cnt_d    = '0;
                        commit_d = ~hdr_q[HDR_LEN-1];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                // The fall before the first data rise must keep the MSB on the wire.
                end else if (sclk_fall && cnt_q != '0) begin
                    miso_d = miso_q << 1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q   <= '0;
            ss_q     <= '0;
            mosi_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hdr_q    <= '0;
            dat_q    <= '0;
            miso_q   <= '0;
            armed_q  <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            sclk_q   <= {sclk_q[1:0], i_sclk};
            ss_q     <= {ss_q[0], i_ss_n};
            mosi_q   <= {mosi_q[0], i_mosi};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            dat_q    <= dat_d;
            miso_q   <= miso_d;
            armed_q  <= armed_d;
            commit_q <= commit_d;
        end
    end

    // Out-of-range addresses match no register, so such writes fall away here.
    always_comb begin
        wr_hit = '0;
        for (int n = 0; n < NUM_REGS; n++)
            if (commit_q && hdr_q[ADDR_W-1:0] == ADDR_W'(n)) wr_hit[n] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q <= RESET_VALUE;
            slot_q <= '0;
            pend_q <= '0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (wr_hit[n] && hdr_q[ADDR_W]) begin
                    live_q[n] <= dat_q;
                    pend_q[n] <= 1'b0;
                end else begin
                    if (load_new && pend_q[n]) begin
                        live_q[n] <= slot_q[n];
                        pend_q[n] <= 1'b0;
                    end
                    if (wr_hit[n]) begin
                        slot_q[n] <= dat_q;
                        pend_q[n] <= 1'b1;
                    end
                end
            end
        end
    end

    assign regs      = live_q;
    assign pending   = pend_q;
    assign o_miso_oe = ss_act & (state_q == DAT) & hdr_q[HDR_LEN-1];
    assign o_miso    = o_miso_oe & miso_q[DATA_W-1];
endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: directed scenarios plus random traffic
// compared against a transaction-level model of live/pending registers.
module tb_spi_regfile;
    logic clk = 1'b0;
    logic reset, load_new;
    logic sclk [3];
    logic ss_n [3];
    logic mosi [3];
    logic miso [3];
    logic oe   [3];
    logic [16*24-1:0] regs0;
    logic [15:0]      pend0;
    logic [2*24-1:0]  regs1;
    logic [1:0]       pend1;
    logic [39:0]      regs2;
    logic [4:0]       pend2;

    always #5 clk = ~clk;

    spi_regfile u_dut0 (
        .clk(clk), .reset(reset), .i_sclk(sclk[0]), .i_ss_n(ss_n[0]), .i_mosi(mosi[0]),
        .o_miso(miso[0]), .o_miso_oe(oe[0]), .load_new(load_new), .regs(regs0), .pending(pend0));
    spi_regfile #(.NUM_REGS(2), .ADDR_W(4), .DATA_W(24)) u_dut1 (
        .clk(clk), .reset(reset), .i_sclk(sclk[1]), .i_ss_n(ss_n[1]), .i_mosi(mosi[1]),
        .o_miso(miso[1]), .o_miso_oe(oe[1]), .load_new(load_new), .regs(regs1), .pending(pend1));
    spi_regfile #(.NUM_REGS(5), .ADDR_W(3), .DATA_W(8), .RESET_VALUE(40'h0102030405)) u_dut2 (
        .clk(clk), .reset(reset), .i_sclk(sclk[2]), .i_ss_n(ss_n[2]), .i_mosi(mosi[2]),
        .o_miso(miso[2]), .o_miso_oe(oe[2]), .load_new(load_new), .regs(regs2), .pending(pend2));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the default instance: live values, pending slots, flags.
    logic [23:0] m_live [16];
    logic [23:0] m_slot [16];
    bit          m_pend [16];

    function automatic void m_reset();
        for (int n = 0; n < 16; n++) begin
            m_live[n] = '0; m_slot[n] = '0; m_pend[n] = 1'b0;
        end
    endfunction

    function automatic void m_load();
        for (int n = 0; n < 16; n++)
            if (m_pend[n]) begin m_live[n] = m_slot[n]; m_pend[n] = 1'b0; end
    endfunction

    function automatic void m_write(input int a, input bit imm, input logic [23:0] d);
        if (imm) begin m_live[a] = d; m_pend[a] = 1'b0; end
        else     begin m_slot[a] = d; m_pend[a] = 1'b1; end
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] p;
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("%s regs[%0d]", tag, n), 64'(regs0[n*24 +: 24]), 64'(m_live[n]));
            p[n] = m_pend[n];
        end
        chk({tag, " pending"}, 64'(pend0), 64'(p));
    endtask

    function automatic logic [63:0] mk(input bit rw, input bit imm, input int a,
                                       input logic [31:0] d, input int aw, input int dw);
        logic [63:0] v;
        v = 64'(rw);
        v = (v << 1) | 64'(imm);
        v = (v << aw) | 64'(a);
        v = (v << dw) | 64'(d);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ss_on(input int d);
        ss_n[d] = 1'b0;
        tick(4);
    endtask

    task automatic ss_off(input int d);
        sclk[d] = 1'b0;
        tick(4);
        ss_n[d] = 1'b1;
        tick(6);
    endtask

    // 8 clk per SCLK bit; MISO/OE sampled just before each rise, as a master would.
    task automatic spi_bits(input int d, input int nb, input int dw, input logic [63:0] val,
                            input bit ln_last, output logic [63:0] rd, output int oe_h, output int oe_d);
        rd = '0; oe_h = 0; oe_d = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            sclk[d] = 1'b0;
            mosi[d] = val[i];
            tick(4);
            if (i < dw) begin
                rd   = {rd[62:0], miso[d]};
                oe_d += int'(oe[d]);
            end else begin
                oe_h += int'(oe[d]);
            end
            sclk[d] = 1'b1;
            if (ln_last && i == 0) begin
                tick(3); load_new = 1'b1; tick(1); load_new = 1'b0;
            end else begin
                tick(4);
            end
        end
    endtask

    task automatic xfer0(input bit rw, input bit imm, input int a, input logic [23:0] d,
                         input bit ln, output logic [23:0] rd);
        logic [63:0] r;
        int oh, od;
        spi_bits(0, 30, 24, mk(rw, imm, a, 32'(d), 4, 24), ln, r, oh, od);
        rd = r[23:0];
        if (ln) m_load();
        if (!rw) m_write(a, imm, d);
        chk("oe in header", 64'(oh), 64'd0);
        chk("oe in data", 64'(od), rw ? 64'd24 : 64'd0);
    endtask

    task automatic pulse_load();
        load_new = 1'b1;
        tick(1);
        load_new = 1'b0;
        m_load();
    endtask

    initial begin
        logic [23:0] rd;
        logic [63:0] r;
        int oh, od, a, op;
        bit imm, ln;
        logic [23:0] d;

        for (int i = 0; i < 3; i++) begin
            sclk[i] = 1'b0; ss_n[i] = 1'b1; mosi[i] = 1'b0;
        end
        load_new = 1'b0;
        reset    = 1'b1;
        m_reset();
        #2;
        check_all("reset");
        chk("reset oe/miso", {62'd0, oe[0], miso[0]}, 64'd0);
        chk("reset sweep regs", 64'(regs2), 64'h0102030405);
        tick(3);
        reset = 1'b0;
        tick(4);

        // deferred write, then promote
        ss_on(0);
        xfer0(0, 0, 3, 24'hA5A5A5, 0, rd);
        check_all("deferred");
        tick(10);
        check_all("deferred hold");
        ss_off(0);
        pulse_load();
        check_all("after load");
        chk("regs[3] loaded", 64'(regs0[3*24 +: 24]), 64'hA5A5A5);

        // immediate write
        ss_on(0);
        xfer0(0, 1, 7, 24'h123ABC, 0, rd);
        check_all("immediate");
        ss_off(0);

        // write then readback in one SS window
        ss_on(0);
        xfer0(0, 1, 2, 24'h00FF00, 0, rd);
        xfer0(1, 0, 2, 24'h0, 0, rd);
        chk("readback", 64'(rd), 64'h00FF00);
        ss_off(0);
        chk("idle oe/miso", {62'd0, oe[0], miso[0]}, 64'd0);
        check_all("read no side effect");

        // collisions with load_new
        ss_on(0);
        xfer0(0, 0, 1, 24'h000011, 0, rd);
        xfer0(0, 0, 1, 24'h000022, 1, rd);
        ss_off(0);
        check_all("collision deferred");
        chk("collision regs[1]", 64'(regs0[1*24 +: 24]), 64'h11);
        pulse_load();
        chk("collision slot", 64'(regs0[1*24 +: 24]), 64'h22);
        ss_on(0);
        xfer0(0, 0, 5, 24'h000055, 0, rd);
        xfer0(0, 1, 5, 24'h000066, 1, rd);
        ss_off(0);
        check_all("collision immediate");

        // abort after 20 of 30 bits, then a clean frame
        ss_on(0);
        spi_bits(0, 20, 0, mk(0, 0, 4, 32'h777777, 4, 24) >> 10, 0, r, oh, od);
        ss_off(0);
        check_all("abort");
        ss_on(0);
        xfer0(0, 0, 4, 24'h456789, 0, rd);
        ss_off(0);
        check_all("after abort");

        // NUM_REGS=2: out-of-range read returns 0, in-range read returns data
        ss_on(1);
        spi_bits(1, 30, 24, mk(0, 1, 1, 32'hABCDEF, 4, 24), 0, r, oh, od);
        spi_bits(1, 30, 24, mk(1, 0, 2, 32'h0, 4, 24), 0, r, oh, od);
        chk("oob read", r, 64'd0);
        chk("oob read oe", 64'(od), 64'd24);
        spi_bits(1, 30, 24, mk(1, 0, 1, 32'h0, 4, 24), 0, r, oh, od);
        chk("dut1 read", r, 64'hABCDEF);
        ss_off(1);

        // parameter sweep instance
        ss_on(2);
        spi_bits(2, 13, 8, mk(0, 0, 6, 32'hFF, 3, 8), 0, r, oh, od);
        chk("sweep oob regs", 64'(regs2), 64'h0102030405);
        chk("sweep oob pending", 64'(pend2), 64'd0);
        spi_bits(2, 13, 8, mk(0, 1, 4, 32'h5A, 3, 8), 0, r, oh, od);
        chk("sweep regs[39:32]", 64'(regs2[39:32]), 64'h5A);
        chk("sweep regs[31:0]", 64'(regs2[31:0]), 64'h02030405);
        ss_off(2);

        // random traffic
        for (int it = 0; it < 30; it++) begin
            op  = int'($urandom_range(0, 3));
            a   = int'($urandom_range(0, 15));
            imm = 1'($urandom_range(0, 1));
            ln  = ($urandom_range(0, 3) == 0);
            d   = 24'($urandom);
            if (op == 3) begin
                pulse_load();
            end else begin
                ss_on(0);
                xfer0(op == 2, imm, a, d, ln, rd);
                if (op == 2) chk($sformatf("rand read[%0d]", a), 64'(rd), 64'(m_live[a]));
                ss_off(0);
            end
            check_all("rand");
        end

        // reset mid-frame: frame continuing without SS toggle is dropped
        ss_on(0);
        spi_bits(0, 10, 0, mk(0, 1, 9, 32'h999999, 4, 24) >> 20, 0, r, oh, od);
        reset = 1'b1;
        #2;
        m_reset();
        check_all("mid reset");
        chk("mid reset sweep", 64'(regs2), 64'h0102030405);
        tick(2);
        reset = 1'b0;
        tick(2);
        xfer0(0, 1, 9, 24'h999999, 0, rd);
        m_reset();
        check_all("post reset no arm");
        ss_off(0);
        ss_on(0);
        xfer0(0, 1, 9, 24'h999999, 0, rd);
        ss_off(0);
        check_all("post reset frame");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of host-writable registers, 1..2**ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 4: width of the register address field in the SPI header.
REQ-003 SHALL have parameter DATA_W, default 24: width of every register and of the SPI data field, 1..32.
REQ-004 SHALL have parameter RESET_VALUE, default all-zero: a NUM_REGS*DATA_W flat vector, where register n occupies bits [n*DATA_W +: DATA_W].
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have ports i_sclk, i_ss_n and i_mosi, each an input of 1 bit: asynchronous SPI mode-0 inputs.
REQ-008 SHALL have port o_miso, output, 1 bit: read data from the block.
REQ-009 SHALL have port o_miso_oe, output, 1 bit: MISO drive enable.
REQ-010 SHALL have port load_new, input, 1 bit: a 1-clk strobe that promotes pending values to live.
REQ-011 SHALL have port regs, output, NUM_REGS*DATA_W bits: the live register values, packed as in REQ-004.
REQ-012 SHALL have port pending, output, NUM_REGS bits: bit n is high while register n holds a value awaiting load_new.

Function
REQ-013 SHALL synchronise SPI inputs as follows: SCLK through a 3-FF chain, using stages 2 and 3 for rise/fall detection; SS_n through 2 FFs; MOSI through 2 FFs. Operation SHALL be guaranteed for SCLK ≤ clk/8.
REQ-014 SHALL use a fixed frame of 2+ADDR_W+DATA_W bits, MSB first, sampled on SCLK rise. The frame fields SHALL be, in order: RW (1 = read), IMM (1 = immediate), ADDR, DATA.
REQ-015 SHALL use a frame FSM with states IDLE → HDR → DAT → IDLE. Synchronised SS inactive SHALL force IDLE from any state. SS active in IDLE SHALL enter HDR with the bit counter at 0.
REQ-016 SHALL leave HDR for DAT on the 2+ADDR_W-th rise. DAT SHALL end on the DATA_W-th data rise, after which the FSM returns to HDR if SS is still active, so that back-to-back frames are accepted without SS toggling.
REQ-017 SHALL, one clk after the final data rise of a write frame (RW=0) with ADDR<NUM_REGS, commit as follows. When IMM=0: the pending slot for ADDR is loaded and pending[ADDR] is set. When IMM=1: the live register is loaded, pending[ADDR] is cleared, and the pending slot is discarded.
REQ-018 SHALL ignore a write frame whose ADDR≥NUM_REGS, with no state change.
REQ-019 SHALL, on load_new, copy every pending slot with its flag set to live and clear those flags in the same clk.
REQ-020 SHALL resolve a load_new that coincides with a commit to the same register as follows. Deferred commit: the old pending value goes live, and the new value stays pending with its flag still set. Immediate commit: the immediate value wins.
REQ-021 SHALL abort a frame when SS deasserts before its final rise: nothing is committed, and pending state is unchanged.
REQ-022 SHALL, for a read frame (RW=1), drive the live value of ADDR on o_miso, MSB first. The value SHALL be loaded at the HDR→DAT transition, and the bit SHALL change on each synchronised SCLK fall. An address ≥NUM_REGS SHALL read 0. A read SHALL never alter registers.
REQ-023 SHALL hold o_miso_oe high only while SS is active and the FSM is in DAT of a read frame. o_miso SHALL be 0 at all other times.

Reset
REQ-024 SHALL, on reset assertion, immediately set regs=RESET_VALUE, pending=0, the FSM to IDLE, the counters to 0, o_miso=0 and o_miso_oe=0.
REQ-025 SHALL abort a frame when reset is applied mid-frame. After reset release, the first frame SHALL be accepted only after SS goes inactive and then active again.

Verification
REQ-026 SHALL be verified by a deferred write: with defaults, write addr 3, data 0xA5A5A5, IMM=0, then pulse load_new. Required response: pending[3]=1 and regs[3] unchanged until load_new, then regs[3]=0xA5A5A5 and pending[3]=0.
REQ-027 SHALL be verified by an immediate write: write addr 7, data 0x123ABC, IMM=1. Required response: regs[7]=0x123ABC 1 clk after the last rise, with no load_new needed.
REQ-028 SHALL be verified by readback: write addr 2, data 0x00FF00, IMM=1, then read addr 2 in the same SS window. Required response: o_miso carries 0x00FF00 MSB first, and o_miso_oe is high only in the data phase. A read of addr 2 when NUM_REGS=2 SHALL return 0.
REQ-029 SHALL be verified by a collision: write addr 1, data 0x000011, deferred; then time the deferred commit of addr 1, data 0x000022, to land on the load_new clk. Required response: regs[1]=0x000011 and pending[1]=1 holding 0x000022.
REQ-030 SHALL be verified by an abort: deassert SS after 20 of 30 bits. Required response: no pending or regs change, and the next full frame commits correctly.
REQ-031 SHALL be verified by a parameter sweep: NUM_REGS=5, ADDR_W=3, DATA_W=8. Required response: a write to addr 6 is ignored, and a write to addr 4 with data 0x5A lands in regs[39:32].
